key_arbiter: RTL and testbench
==============================

KEY_ARBITER -- requirements
Module: key_arbiter

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 48, meaning number of piano keys (4 octaves x 12).
REQ-002 SHALL have parameter IDX_W, default 6, meaning width of the key index.
REQ-003 SHALL have parameter NONE_IDX, default 63, meaning index reported when no key is selected.
REQ-004 SHALL have port clk2  input  1  meaning pixel clock; the block's one clock.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port key_down  input  NUM_KEYS  meaning level per key, 1 = held; synchronous to clk2.
REQ-007 SHALL have port frame_start  input  1  meaning one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port arbiter  output  IDX_W  meaning committed key index for the pixel generator.
REQ-009 SHALL have port key_valid  output  1  meaning arbiter holds a real key.
REQ-010 SHALL have port changed  output  1  meaning one-cycle pulse when the committed value changes.

Function
REQ-011 SHALL register key_down into key_prev every cycle; press vector = key_down & ~key_prev.
REQ-012 SHALL keep a selection register sel (IDX_W) plus a two-state FSM: IDLE (no key), HELD (sel valid).
REQ-013 IDLE -> HELD when press is non-zero: sel <= lowest set index of press.
REQ-014 HELD, press non-zero: sel <= lowest set index of press (newest press wins); stay HELD.
REQ-015 HELD, press zero, key_down[sel]=1: hold sel.
REQ-016 HELD, press zero, key_down[sel]=0, key_down non-zero: sel <= lowest set index of key_down; stay HELD.
REQ-017 HELD, press zero, key_down all zero: sel <= NONE_IDX; -> IDLE.
REQ-018 Simultaneous release of sel and press of another key in one cycle: the press wins (REQ-014).
REQ-019 Multiple simultaneous presses: lowest index wins; tie-break is fixed, not round-robin.
REQ-020 sel and FSM state SHALL reflect a key_down change made in cycle N at cycle N+1.
REQ-021 On frame_start=1: arbiter <= sel, key_valid <= (state==HELD), using register values in that cycle; otherwise arbiter and key_valid hold.
REQ-022 changed SHALL be 1 for exactly the cycle after a frame_start commit whose {arbiter,key_valid} differs from the previous committed value; 0 otherwise.
REQ-023 Latency: key edge in cycle N with frame_start in cycle N+1 -> arbiter updated in cycle N+2.
REQ-024 Key indices >= NUM_KEYS SHALL never be produced; arbiter is NONE_IDX whenever key_valid=0.
REQ-025 frame_start asserted on consecutive cycles SHALL commit on each; no internal edge detection on it.

Reset
REQ-026 rst SHALL asynchronously force: key_prev=0, state=IDLE, sel=NONE_IDX, arbiter=NONE_IDX, key_valid=0, changed=0.
REQ-027 Keys held when rst deasserts SHALL be treated as new presses in the first post-reset cycle (key_prev=0).
REQ-028 rst asserted mid-frame SHALL drop the committed key immediately; no commit until the next frame_start.

Structure
REQ-029 Shared package key_pkg SHALL hold NUM_KEYS, IDX_W, NONE_IDX, KEYS_PER_OCT=12 and the FSM state typedef {IDLE, HELD}.
REQ-030 One sub-module, lowest_set_enc, SHALL implement the NUM_KEYS-to-IDX_W lowest-set-bit encoder with an any-set flag; instantiated twice (press, key_down).
REQ-031 All outputs SHALL be driven directly from registers.

Verification
REQ-032 Reset, then key_down[5]=1 at cycle 10, frame_start at cycle 12 -> arbiter=5, key_valid=1, changed=1 at cycle 13.
REQ-033 Keys 5 held, press 20 -> sel=20; release 20 -> sel=5; release 5 -> sel=63, key_valid=0 after next frame_start.
REQ-034 key_down[3] and key_down[40] rising in same cycle -> sel=3; then release 3 and press 7 in same cycle -> sel=7.
REQ-035 Key changes 10->11->12 between frame_starts -> arbiter only ever shows 12, with one changed pulse; no frame_start -> arbiter stays at old value.
REQ-036 Key 47 held, rst pulsed mid-frame -> arbiter=63, key_valid=0 immediately; after release of rst, next frame_start -> arbiter=47.
REQ-037 Two frame_starts with unchanged selection -> changed stays 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and FSM state type for the piano key arbiter.
// The pixel path consumes these through key_arbiter's parameters.
package key_pkg;
  localparam int NUM_KEYS     = 48;
  localparam int IDX_W        = 6;
  localparam int NONE_IDX     = 63;
  localparam int KEYS_PER_OCT = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;
endpackage

// File: rtl/lowest_set_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest 1 in vec plus an any-set flag.
// The index output is 0 when no bit is set; callers qualify it with any.
module lowest_set_enc
  import key_pkg::*;
#(
  parameter int NUM_KEYS = key_pkg::NUM_KEYS,
  parameter int IDX_W    = key_pkg::IDX_W
) (
  input  logic [NUM_KEYS-1:0] vec,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = {IDX_W{1'b0}};
    any = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
      any = any | vec[i];
    end
  end

endmodule

// File: rtl/key_arbiter.sv
// Picks one held piano key (newest press wins, lowest index on ties) and
// commits it to the pixel generator once per frame at frame_start.
module key_arbiter
  import key_pkg::*;
#(
  parameter int NUM_KEYS = key_pkg::NUM_KEYS,
  parameter int IDX_W    = key_pkg::IDX_W,
  parameter int NONE_IDX = key_pkg::NONE_IDX
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_down,
  input  logic                frame_start,
  output logic [IDX_W-1:0]    arbiter,
  output logic                key_valid,
  output logic                changed
);

  logic [NUM_KEYS-1:0] key_prev;
  logic [IDX_W-1:0]    sel;
  key_state_t          state;

  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] sel_mask_s;
  logic [IDX_W-1:0]    press_idx_s;
  logic [IDX_W-1:0]    down_idx_s;
  logic                press_any_s;
  logic                down_any_s;
  logic                sel_held_s;
  logic                sel_valid_s;

  assign press_s     = key_down & ~key_prev;
  // A NONE_IDX selection shifts the bit out entirely, so the mask is empty.
  assign sel_mask_s  = {{(NUM_KEYS-1){1'b0}}, 1'b1} << sel;
  assign sel_held_s  = |(key_down & sel_mask_s);
  assign sel_valid_s = (state == HELD);

  lowest_set_enc #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_press_enc (
    .vec (press_s),
    .idx (press_idx_s),
    .any (press_any_s)
  );

  lowest_set_enc #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_down_enc (
    .vec (key_down),
    .idx (down_idx_s),
    .any (down_any_s)
  );

  // Selection FSM plus frame-synchronous commit of the selection to the outputs.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      key_prev  <= {NUM_KEYS{1'b0}};
      state     <= IDLE;
      sel       <= IDX_W'(NONE_IDX);
      arbiter   <= IDX_W'(NONE_IDX);
      key_valid <= 1'b0;
      changed   <= 1'b0;
    end else begin
      key_prev <= key_down;

      case (state)
        IDLE: begin
          if (press_any_s) begin
            state <= HELD;
            sel   <= press_idx_s;
          end else begin
            state <= IDLE;
            sel   <= IDX_W'(NONE_IDX);
          end
        end
        HELD: begin
          if (press_any_s) begin
            state <= HELD;
            sel   <= press_idx_s;
          end else if (sel_held_s) begin
            state <= HELD;
            sel   <= sel;
          end else if (down_any_s) begin
            state <= HELD;
            sel   <= down_idx_s;
          end else begin
            state <= IDLE;
            sel   <= IDX_W'(NONE_IDX);
          end
        end
        default: begin
          state <= IDLE;
          sel   <= IDX_W'(NONE_IDX);
        end
      endcase

      // Commit uses the pre-edge selection, so a key edge needs one extra cycle.
      if (frame_start) begin
        arbiter   <= sel;
        key_valid <= sel_valid_s;
        changed   <= (sel != arbiter) || (sel_valid_s != key_valid);
      end else begin
        arbiter   <= arbiter;
        key_valid <= key_valid;
        changed   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_arbiter.sv
// Self-checking bench for key_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_key_arbiter;

  localparam int NK   = 48;
  localparam int NONE = 63;

  logic          clk2;
  logic          rst;
  logic [NK-1:0] key_down;
  logic          frame_start;
  logic [5:0]    arbiter;
  logic          key_valid;
  logic          changed;

  int total;
  int bad;

  // Behavioural model: selection as an integer (-1 = nothing held).
  int          m_sel;
  logic [NK-1:0] m_prev;
  int          m_arb;
  logic        m_valid;
  logic        m_chg;

  typedef struct {
    logic [NK-1:0] kd;
    logic          fs;
    logic [5:0]    a;
    logic          v;
    logic          c;
  } vec_t;

  vec_t tbl[25];

  key_arbiter dut (
    .clk2        (clk2),
    .rst         (rst),
    .key_down    (key_down),
    .frame_start (frame_start),
    .arbiter     (arbiter),
    .key_valid   (key_valid),
    .changed     (changed)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  function automatic logic [NK-1:0] k(input int n);
    logic [NK-1:0] one;
    one = 48'd1;
    return one << n;
  endfunction

  function automatic int lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel   = -1;
    m_prev  = '0;
    m_arb   = NONE;
    m_valid = 1'b0;
    m_chg   = 1'b0;
  endtask

  task automatic model_step(input logic [NK-1:0] kd, input logic fs);
    logic [NK-1:0] press;
    int            new_arb;
    logic          new_valid;
    press = kd & ~m_prev;
    if (fs) begin
      new_arb   = (m_sel < 0) ? NONE : m_sel;
      new_valid = (m_sel >= 0);
      m_chg     = (new_arb != m_arb) || (new_valid != m_valid);
      m_arb     = new_arb;
      m_valid   = new_valid;
    end else begin
      m_chg = 1'b0;
    end
    if (press != '0) m_sel = lowest(press);
    else if (m_sel >= 0 && kd[m_sel]) m_sel = m_sel;
    else m_sel = lowest(kd);
    m_prev = kd;
  endtask

  task automatic tick(input logic [NK-1:0] kd, input logic fs);
    key_down    = kd;
    frame_start = fs;
    @(posedge clk2);
    model_step(kd, fs);
    #1;
  endtask

  task automatic do_reset(input logic [NK-1:0] kd);
    rst         = 1'b1;
    key_down    = kd;
    frame_start = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    chk("reset_arbiter", arbiter, NONE);
    chk("reset_valid", key_valid, 0);
    chk("reset_changed", changed, 0);
    @(negedge clk2);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_arbiter"}, arbiter, m_arb);
    chk({tag, "_valid"}, key_valid, m_valid);
    chk({tag, "_changed"}, changed, m_chg);
  endtask

  initial begin
    logic [NK-1:0] kd;
    total = 0;
    bad   = 0;
    model_reset();

    tbl[0]  = '{'0,              1'b0, 6'd63, 1'b0, 1'b0};
    tbl[1]  = '{k(5),            1'b0, 6'd63, 1'b0, 1'b0};
    tbl[2]  = '{k(5),            1'b1, 6'd5,  1'b1, 1'b1};
    tbl[3]  = '{k(5),            1'b0, 6'd5,  1'b1, 1'b0};
    tbl[4]  = '{k(5) | k(20),    1'b0, 6'd5,  1'b1, 1'b0};
    tbl[5]  = '{k(5) | k(20),    1'b1, 6'd20, 1'b1, 1'b1};
    tbl[6]  = '{k(5),            1'b1, 6'd20, 1'b1, 1'b0};
    tbl[7]  = '{k(5),            1'b1, 6'd5,  1'b1, 1'b1};
    tbl[8]  = '{'0,              1'b0, 6'd5,  1'b1, 1'b0};
    tbl[9]  = '{'0,              1'b1, 6'd63, 1'b0, 1'b1};
    tbl[10] = '{k(3) | k(40),    1'b0, 6'd63, 1'b0, 1'b0};
    tbl[11] = '{k(40) | k(7),    1'b1, 6'd3,  1'b1, 1'b1};
    tbl[12] = '{k(40) | k(7),    1'b1, 6'd7,  1'b1, 1'b1};
    tbl[13] = '{k(40) | k(7),    1'b1, 6'd7,  1'b1, 1'b0};
    tbl[14] = '{k(40),           1'b0, 6'd7,  1'b1, 1'b0};
    tbl[15] = '{k(40),           1'b1, 6'd40, 1'b1, 1'b1};
    tbl[16] = '{'0,              1'b0, 6'd40, 1'b1, 1'b0};
    tbl[17] = '{k(10),           1'b0, 6'd40, 1'b1, 1'b0};
    tbl[18] = '{k(11),           1'b0, 6'd40, 1'b1, 1'b0};
    tbl[19] = '{k(12),           1'b0, 6'd40, 1'b1, 1'b0};
    tbl[20] = '{k(12),           1'b1, 6'd12, 1'b1, 1'b1};
    tbl[21] = '{k(12),           1'b0, 6'd12, 1'b1, 1'b0};
    tbl[22] = '{'0,              1'b0, 6'd12, 1'b1, 1'b0};
    tbl[23] = '{'0,              1'b0, 6'd12, 1'b1, 1'b0};
    tbl[24] = '{'0,              1'b1, 6'd63, 1'b0, 1'b1};

    // Directed table.
    do_reset('0);
    for (int i = 0; i < 25; i++) begin
      tick(tbl[i].kd, tbl[i].fs);
      chk($sformatf("tbl%0d_arbiter", i), arbiter, tbl[i].a);
      chk($sformatf("tbl%0d_valid", i), key_valid, tbl[i].v);
      chk($sformatf("tbl%0d_changed", i), changed, tbl[i].c);
    end

    // Exact latency: key at cycle 10, frame_start at cycle 12, visible at 13.
    do_reset('0);
    for (int c = 0; c < 15; c++) begin
      tick((c >= 10) ? k(5) : '0, c == 12);
      if (c == 11) chk("lat_early_arbiter", arbiter, NONE);
      if (c == 12) begin
        chk("lat_arbiter", arbiter, 5);
        chk("lat_valid", key_valid, 1);
        chk("lat_changed", changed, 1);
      end
      if (c == 13) chk("lat_changed_drop", changed, 0);
    end

    // Asynchronous reset mid-frame with key 47 held.
    tick(k(47), 1'b0);
    tick(k(47), 1'b1);
    chk("k47_arbiter", arbiter, 47);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_arbiter", arbiter, NONE);
    chk("async_rst_valid", key_valid, 0);
    @(negedge clk2);
    rst = 1'b0;
    model_reset();
    tick(k(47), 1'b0);
    chk("post_rst_nocommit", arbiter, NONE);
    tick(k(47), 1'b1);
    chk("post_rst_arbiter", arbiter, 47);
    chk("post_rst_valid", key_valid, 1);
    chk("post_rst_changed", changed, 1);

    // Keys held through reset count as fresh presses.
    do_reset(k(30) | k(9));
    tick(k(30) | k(9), 1'b0);
    tick(k(30) | k(9), 1'b1);
    chk("held_thru_rst", arbiter, 9);

    // Randomized traffic against the model.
    do_reset('0);
    kd = '0;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) kd = kd ^ k($urandom_range(0, NK - 1));
      else if (r == 6) kd = kd ^ k($urandom_range(0, NK - 1)) ^ k($urandom_range(0, NK - 1));
      else if (r == 7) kd = '0;
      tick(kd, $urandom_range(0, 2) == 0);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
